// File: rtl/i2c_segment_target_if.sv
// rtl/i2c_segment_target_if.sv - I2C pin bundle between bus master side and segment target
interface i2c_segment_target_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe;

    modport master (output scl_i, output sda_i, input sda_oe);
    modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_segment_target.sv
// rtl/i2c_segment_target.sv - I2C target with DATA/CTRL/BLINK registers driving a 7-segment display
module i2c_segment_target #(
    parameter logic [6:0] ADDR        = 7'h3C,
    parameter int         BLINK_PRE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_segment_target_if.slave   bus,
    output logic [7:0]            seg,
    output logic                  busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
    } state_t;

    state_t     state, state_n;
    logic [2:0] scl_sync, sda_sync;
    logic [3:0] bit_cnt, cnt_n;
    logic [7:0] rx_sr, rx_n;
    logic [7:0] tx_sr, tx_n;
    logic [1:0] ptr, ptr_n;
    logic       sda_oe_q, oe_n;
    logic       busy_q, busy_n;
    logic       wr_en;
    logic [7:0] data_reg, ctrl_reg, blink_reg, rd_data;

    logic [BLINK_PRE_W-1:0] pre_cnt;
    logic [7:0]             half_cnt;
    logic                   phase_on;
    logic                   blink_clr;
    logic [7:0]             disp;

    // [1] is the synchronized level, [2] the previous one for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], bus.scl_i};
            sda_sync <= {sda_sync[1:0], bus.sda_i};
        end
    end

    wire scl_rise  =  scl_sync[1] & ~scl_sync[2];
    wire scl_fall  = ~scl_sync[1] &  scl_sync[2];
    wire start_det =  scl_sync[1] &  scl_sync[2] & ~sda_sync[1] &  sda_sync[2];
    wire stop_det  =  scl_sync[1] &  scl_sync[2] &  sda_sync[1] & ~sda_sync[2];
    wire sda_bit   =  sda_sync[1];

    always_comb begin
        case (ptr)
            2'd0:    rd_data = data_reg;
            2'd1:    rd_data = ctrl_reg;
            2'd2:    rd_data = blink_reg;
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            bit_cnt  <= 4'd0;
            rx_sr    <= 8'h00;
            tx_sr    <= 8'h00;
            ptr      <= 2'd0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= cnt_n;
            rx_sr    <= rx_n;
            tx_sr    <= tx_n;
            ptr      <= ptr_n;
            sda_oe_q <= oe_n;
            busy_q   <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        rx_n    = rx_sr;
        tx_n    = tx_sr;
        ptr_n   = ptr;
        oe_n    = sda_oe_q;
        busy_n  = busy_q;
        wr_en   = 1'b0;
        if (start_det) begin
            state_n = S_ADDR;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (stop_det) begin
            state_n = S_IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        rx_n  = {rx_sr[6:0], sda_bit};
                        cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        // This fall ends bit 8: commit and start the ACK together
                        cnt_n = 4'd0;
                        if (state == S_ADDR) begin
                            if (rx_sr[7:1] == ADDR) begin
                                state_n = S_ADDR_ACK;
                                oe_n    = 1'b1;
                                busy_n  = 1'b1;
                            end else begin
                                state_n = S_IGNORE;
                            end
                        end else if (state == S_PTR) begin
                            ptr_n   = rx_sr[1:0];
                            state_n = S_PTR_ACK;
                            oe_n    = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            ptr_n   = ptr + 2'd1;
                            state_n = S_WDATA_ACK;
                            oe_n    = 1'b1;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rx_sr[0]) begin
                            state_n = S_RDATA;
                            tx_n    = {rd_data[6:0], 1'b0};
                            oe_n    = ~rd_data[7];
                        end else begin
                            state_n = S_PTR;
                            oe_n    = 1'b0;
                        end
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        state_n = S_WDATA;
                        oe_n    = 1'b0;
                    end
                end
                S_RDATA: begin
                    if (scl_rise) begin
                        cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            oe_n    = 1'b0;
                            ptr_n   = ptr + 2'd1;
                            cnt_n   = 4'd0;
                            state_n = S_RDATA_ACK;
                        end else begin
                            oe_n = ~tx_sr[7];
                            tx_n = {tx_sr[6:0], 1'b0};
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (scl_rise && sda_bit) begin
                        state_n = S_IDLE;
                        busy_n  = 1'b0;
                    end else if (scl_fall) begin
                        state_n = S_RDATA;
                        tx_n    = {rd_data[6:0], 1'b0};
                        oe_n    = ~rd_data[7];
                        cnt_n   = 4'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= 8'h00;
            ctrl_reg  <= 8'h05;
            blink_reg <= 8'h00;
        end else if (wr_en) begin
            case (ptr)
                2'd0:    data_reg  <= rx_sr;
                2'd1:    ctrl_reg  <= rx_sr;
                2'd2:    blink_reg <= rx_sr;
                default: begin
                end
            endcase
        end
    end

    assign blink_clr = wr_en && (ptr == 2'd1 || ptr == 2'd2);

    // Half period = 2^BLINK_PRE_W prescaler wraps times (BLINK+1)
    always_ff @(posedge clk) begin
        if (rst || blink_clr) begin
            pre_cnt  <= '0;
            half_cnt <= 8'd0;
            phase_on <= 1'b1;
        end else begin
            pre_cnt <= pre_cnt + BLINK_PRE_W'(1);
            if (&pre_cnt) begin
                if (half_cnt == blink_reg) begin
                    half_cnt <= 8'd0;
                    phase_on <= ~phase_on;
                end else begin
                    half_cnt <= half_cnt + 8'd1;
                end
            end
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        disp = ctrl_reg[0] ? {data_reg[7], hex7(data_reg[3:0])} : data_reg;
        if (!ctrl_reg[2] || (ctrl_reg[1] && !phase_on)) begin
            disp = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= 8'h00;
        end else begin
            seg <= disp;
        end
    end

    assign bus.sda_oe = sda_oe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_segment_target.sv
// tb/tb_i2c_segment_target.sv - directed and randomized I2C transactions against a register/display model
module tb_i2c_segment_target;
    localparam int PRE_W = 4;
    localparam int Q     = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] seg;
    logic       busy;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;

    always #5 clk = ~clk;

    i2c_segment_target_if bus();
    assign bus.scl_i = m_scl;
    assign bus.sda_i = m_sda & ~bus.sda_oe;

    i2c_segment_target #(.ADDR(7'h3C), .BLINK_PRE_W(PRE_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .seg  (seg),
        .busy (busy)
    );

    int         total = 0;
    int         bad   = 0;
    logic       oe_acc = 1'b0;
    logic [7:0] mregs [4];
    logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            oe_acc = oe_acc | bus.sda_oe;
        end
    endtask

    function automatic logic [7:0] exp_seg(input logic [7:0] d, input logic [7:0] c);
        if (!c[2]) return 8'h00;
        if (c[0]) return {d[7], hex_tbl[d[3:0]]};
        return d;
    endfunction

    task automatic send_bit(input logic b, output logic s);
        m_sda = b;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        s = bus.sda_i;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b1;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d, output logic oe_ack);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, s);
            d = {d[6:0], s};
        end
        m_sda  = ~mack;
        oe_acc = 1'b0;
        tick(Q);
        m_scl = 1'b1;
        tick(2 * Q);
        oe_ack = oe_acc;
        m_scl  = 1'b0;
        tick(Q);
    endtask

    task automatic wr_txn(input logic [7:0] q [$], output int acks);
        logic a;
        acks = 0;
        i2c_start();
        foreach (q[i]) begin
            write_byte(q[i], a);
            acks += int'(a);
        end
        i2c_stop();
        tick(4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        m_scl = 1'b1;
        m_sda = 1'b1;
        tick(3);
        chk("rst_seg", seg, 8'h00);
        chk("rst_oe", bus.sda_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick(1);
        chk("rst_seg_release", seg, 8'h3F);
        mregs = '{8'h00, 8'h05, 8'h00, 8'h00};
    endtask

    task automatic readback(input string tag);
        logic       a;
        logic       o;
        logic [7:0] d;
        int         acks;
        acks = 0;
        i2c_start();
        write_byte(8'h78, a); acks += int'(a);
        write_byte(8'h00, a); acks += int'(a);
        i2c_start();
        write_byte(8'h79, a); acks += int'(a);
        chk({tag, "_acks"}, acks, 3);
        for (int i = 0; i < 4; i++) begin
            read_byte(i < 3, d, o);
            chk({tag, "_data"}, d, mregs[i]);
            chk({tag, "_oe_mack"}, o, 1'b0);
        end
        i2c_stop();
        tick(4);
    endtask

    initial begin
        logic [7:0] q [$];
        logic       a;
        logic       o;
        logic [7:0] d;
        logic [7:0] s1;
        int         acks;
        int         n;
        int         hp;
        int         p;
        int         nb;
        int         mp;

        do_reset();

        // DATA=0x85 with decode on shows '5' plus dp
        acks = 0;
        i2c_start();
        write_byte(8'h78, a); acks += int'(a);
        write_byte(8'h00, a); acks += int'(a);
        chk("busy_in_write", busy, 1'b1);
        write_byte(8'h85, a); acks += int'(a);
        i2c_stop();
        tick(4);
        chk("w1_acks", acks, 3);
        chk("w1_seg", seg, 8'hED);
        chk("w1_busy_after_stop", busy, 1'b0);

        do_reset();
        oe_acc = 1'b0;
        q = {8'h7A, 8'h00, 8'h12, 8'h34};
        wr_txn(q, acks);
        chk("wrong_addr_oe", oe_acc, 1'b0);
        chk("wrong_addr_acks", acks, 0);
        chk("wrong_addr_seg", seg, 8'h3F);

        do_reset();
        q = {8'h78, 8'h00, 8'h49, 8'h04};
        wr_txn(q, acks);
        chk("autoinc_acks", acks, 4);
        chk("autoinc_seg", seg, 8'h49);

        do_reset();
        i2c_start();
        write_byte(8'h78, a);
        write_byte(8'h01, a);
        i2c_start();
        write_byte(8'h79, a);
        chk("rd_addr_ack", a, 1'b1);
        read_byte(1'b1, d, o);
        chk("rd_b0", d, 8'h05);
        chk("rd_b0_oe", o, 1'b0);
        read_byte(1'b1, d, o);
        chk("rd_b1", d, 8'h00);
        chk("rd_b1_oe", o, 1'b0);
        read_byte(1'b0, d, o);
        chk("rd_b2", d, 8'h00);
        chk("rd_b2_oe", o, 1'b0);
        chk("rd_busy_after_nack", busy, 1'b0);
        i2c_stop();
        tick(4);

        // A STOP inside a data byte must not commit it
        do_reset();
        i2c_start();
        write_byte(8'h78, a);
        write_byte(8'h00, a);
        for (int i = 0; i < 3; i++) send_bit(1'b1, a);
        i2c_stop();
        tick(4);
        chk("partial_seg", seg, 8'h3F);
        readback("partial_rb");

        do_reset();
        for (int t = 0; t < 6; t++) begin
            p  = int'($urandom_range(0, 3));
            nb = int'($urandom_range(1, 3));
            q  = {8'h78, 8'(p)};
            mp = p;
            for (int k = 0; k < nb; k++) begin
                d = 8'($urandom);
                if (mp == 1) d[1] = 1'b0;
                q.push_back(d);
                if (mp != 3) mregs[mp] = d;
                mp = (mp + 1) % 4;
            end
            wr_txn(q, acks);
            chk("rnd_acks", acks, nb + 2);
            chk("rnd_seg", seg, exp_seg(mregs[0], mregs[1]));
        end
        readback("rnd_rb");

        do_reset();
        hp = int'($urandom_range(0, 3));
        q  = {8'h78, 8'h01, 8'h07, 8'(hp)};
        hp = (1 << PRE_W) * (hp + 1);
        wr_txn(q, acks);
        chk("blink_acks", acks, 4);
        s1 = seg;
        n  = 0;
        do begin tick(1); n++; end while (seg == s1 && n < 1000);
        s1 = seg;
        chk("blink_level", (s1 == 8'h3F || s1 == 8'h00), 1'b1);
        n = 0;
        do begin tick(1); n++; end while (seg == s1 && n < 1000);
        chk("blink_half1", n, hp);
        chk("blink_alt", seg, (s1 == 8'h00) ? 8'h3F : 8'h00);
        s1 = seg;
        n  = 0;
        do begin tick(1); n++; end while (seg == s1 && n < 1000);
        chk("blink_half2", n, hp);

        i2c_start();
        write_byte(8'h78, a);
        write_byte(8'h00, a);
        send_bit(1'b1, a);
        send_bit(1'b0, a);
        send_bit(1'b1, a);
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        rst = 1'b1;
        tick(2);
        chk("midrst_oe", bus.sda_oe, 1'b0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("midrst_seg", seg, 8'h3F);
        mregs = '{8'h00, 8'h05, 8'h00, 8'h00};
        readback("midrst_rb");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_segment_target.md
# i2c_segment_target

I2C target (slave) with a small register file that controls the 7-segment display output of the segment controller. It oversamples SCL/SDA from the bidirectional pins, decodes write/read transactions at address `ADDR`, and drives the `seg` pattern with optional hex decode, display enable and blink. It sits between the top-level `uio` pins (I2C) and `uo_out` (segments).

## Interface

- `ADDR`, 7'h3C, 7-bit I2C target address.
- `BLINK_PRE_W`, 16, prescaler width. Blink half-period is 2^BLINK_PRE_W × (BLINK+1) clk cycles.

- `clk`  in  1  system clock; must be ≥ 8× SCL frequency.
- `rst`  in  1  reset, synchronous, active-high.
- `scl_i`  in  1  raw SCL from pin, asynchronous.
- `sda_i`  in  1  raw SDA from pin, asynchronous.
- `sda_oe`  out  1  1 = pull SDA low (open drain); 0 = release.
- `seg`  out  8  segment drive: bit0..6 = a..g, bit7 = dp; registered.
- `busy`  out  1  1 from address match (ACK) until STOP, START or NACK-ended read.

## Operation

- SCL/SDA pass through 2-FF synchronizers, then a third register for edge detect. Every event is seen 2–3 clk after the pin change.
- START: SDA fall while SCL high. STOP: SDA rise while SCL high. START in any state (including repeated START) goes to ADDR and clears the bit counter. STOP in any state goes to IDLE.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR shifts 8 bits MSB-first on SCL rise.
  - Bits[7:1] == ADDR: go to ADDR_ACK.
  - Otherwise: go to IGNORE, which holds until START/STOP. `sda_oe` never asserts in IGNORE.
- After the address ACK:
  - R/W=0: PTR. First data byte loads the 2-bit register pointer from byte[1:0], ACKed. Subsequent bytes go to WDATA.
  - R/W=1: RDATA, starting at the current pointer.
- Registers:
  - 0x0 DATA, reset 0x00.
  - 0x1 CTRL, reset 0x05. bit0 decode, bit1 blink, bit2 display enable, bits[7:3] read as written.
  - 0x2 BLINK, reset 0x00.
  - 0x3 unimplemented: writes ignored but ACKed, reads return 0x00.
- Pointer auto-increments after each data byte written or read and wraps 3→0.
- Write commit: the register is updated on the SCL fall ending bit 8. That same edge asserts ACK.
- ACK (target): `sda_oe`=1 from the SCL fall after bit 8 until the next SCL fall.
- Read: the target drives bit7 of the register on the SCL fall after the address ACK / previous RDATA_ACK. Each bit is driven as `sda_oe` = ~bit on SCL fall. `sda_oe` is released for the master ACK bit.
  - Master ACK (SDA low, sampled on SCL rise): next byte.
  - Master NACK: IDLE, wait for STOP/START.
- Display:
  - decode=1: seg[6:0] = hex table of DATA[3:0] (0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71), seg[7] = DATA[7].
  - decode=0: seg = DATA.
  - display enable=0, or blink=1 in off phase: seg = 0x00.
- Blink: prescaler plus 8-bit half-period counter. Phase starts "on". Any write to CTRL or BLINK clears the counters and sets phase "on". BLINK=0xFF is the longest period; there is no disable value other than CTRL.bit1.

## Timing

- Reset (sync): all registers to reset values, FSM IDLE, `sda_oe`=0, `busy`=0, `seg`=0x00. The first clk with `rst` low loads `seg`=0x3F.
- `seg` updates exactly 1 clk after the register commit or blink phase toggle.
- `sda_oe` changes 1 clk after the detected SCL fall. That is ≤4 clk after the pin edge, within SCL low time at ≥8× oversampling.
- `busy` rises with the address ACK assertion and falls 1 clk after STOP/START detection or a read NACK.
- Reset asserted mid-transaction: abort immediately, release SDA, no partial register write.
- START and STOP inside a data byte: the byte is discarded with no commit.

## Test plan

- Reset → `seg`=0x00 during `rst`, 0x3F one clk after release; `sda_oe`=0, `busy`=0.
- Write 0x78 (0x3C W), 0x00, 0x85, STOP at 100 kHz-equivalent (clk=16×SCL) → 3 ACKs, `seg`=0xED, `busy` low after STOP.
- Write to address 0x3D with any bytes → `sda_oe` never 1, registers unchanged, `seg`=0x3F.
- Write 0x78, 0x00, 0x49, 0x04 → auto-increment: DATA=0x49, CTRL=0x04 (raw), `seg`=0x49.
- Write 0x78, 0x01, repeated START, 0x79, read 3 bytes (ACK, ACK, NACK), STOP → returns 0x05, 0x00, 0x00; `sda_oe` released for master ACK bits.
- CTRL=0x07, BLINK=0 → `seg` alternates 0x3F/0x00 every 65536 clk. Assert `rst` mid-byte of a later write → SDA released, registers at reset values.
